rmii_frame_tx: RTL and testbench
================================

// Module: rmii_frame_tx
// PURPOSE
// - RMII (2-bit) Ethernet transmit serializer; sits between the MAC byte stream and the PHY RMII TX pins.
// - On start, emits preamble+SFD, then streams bytes as dibits, LSB dibit first, with an optional FCS.
// - Finishes with an inter-packet gap; requests each next byte with a one-cycle done_o pulse.
// PARAMETERS
// - PREAMBLE_BYTES  7   number of 0x55 bytes before SFD 0xD5
// - IPG_BYTES       12  inter-packet gap length in bytes (4 enabled cycles per byte)
// PORTS
// - ref_clk  in   1  50 MHz RMII reference clock; the single clock
// - rst_n    in   1  reset; synchronous, active-high (despite the name)
// - data     in   8  current payload byte; sampled at byte load
// - en_i     in   1  clock enable; state and outputs advance only on edges with en_i=1 (1 = 100M; pulse 1-in-10 = 10M)
// - start_i  in   1  level; begins a frame when sampled high in IDLE
// - last_i   in   1  sampled with data; 1 marks the final payload byte
// - tx_d     out  2  RMII TXD[1:0]
// - tx_e     out  1  RMII TX_EN
// - done_o   out  1  one-cycle pulse: byte just loaded, present next data/last_i
// BEHAVIOUR
// - Reset: state=IDLE, tx_d=2'b00, tx_e=0, done_o=0, counters and CRC cleared; takes priority, aborts a frame mid-flight.
// - All outputs are registered. en_i=0 freezes state, tx_d and tx_e; done_o is forced 0 on every non-load edge.
// - States: IDLE -> PRE -> DATA -> (FCS) -> IPG -> IDLE.
// - IDLE: tx_e=0, tx_d=00. On an enabled edge with start_i=1, go to PRE.
// - PRE: tx_e=1 for 4*(PREAMBLE_BYTES+1) enabled edges.
// - PRE dibits: 2'b01 on all of them except the last, which is 2'b11 (0x55 x N, then 0xD5, LSB first).
// - Numbering: edge k counts enabled edges from the start edge (k=0). Preamble dibit k is output after edge k, k=0..31.
// - DATA load: on enabled edge 32+4n, sample data and last_i into shift register; tx_d<=data[1:0]; done_o<=1 next cycle.
// - DATA shift: the next three enabled edges output bits [3:2], [5:4], [7:6].
// - Source has until the next load edge (4 enabled edges) to update data.
// - After the 4th dibit of a byte loaded with last_i=1, go to FCS if compiled in, else to IPG.
// - IPG: tx_e=0, tx_d=00 for 4*IPG_BYTES enabled edges, then IDLE. start_i is ignored until IDLE.
// - start_i still high in IDLE restarts immediately (back-to-back frames separated by the full IPG).
// - start_i, last_i changes outside their sampling edges are ignored. Zero-length frames are impossible: at least one byte is sent.
// CONFIGURATION
// - Macro TX_FCS_EN defined: CRC-32 over all payload bytes and FCS state after the last byte.
//   - CRC: reflected poly 0xEDB88320, init 0xFFFFFFFF, updated per dibit as sent.
//   - FCS state: 16 dibits of ~CRC, LSB first, tx_e=1. done_o does not pulse during FCS.
// - Macro undefined: no CRC logic; after the last byte go straight to IPG.
// TESTING
// - Reset: rst_n=1 for 2 cycles -> tx_e=0, tx_d=00, done_o=0; then release with start_i=0 -> stays idle.
// - start_i=1, en_i=1, data=0xC3, last_i=1 -> 31x 01, then 11; then dibits 11,00,00,11.
//   - done_o single pulse one cycle after edge 32; then 48 cycles tx_e=0 (no FCS).
// - Two bytes 0xC3 then 0x91 (set after first done_o, last_i=1 with 0x91):
//   - second byte dibits 01,00,01,10; exactly two done_o pulses; frame ends.
// - en_i pulsed 1 cycle in 10 -> same dibit sequence, each dibit held 10 cycles; done_o still 1 cycle wide.
// - TX_FCS_EN, payload ASCII "123456789" -> FCS bytes 26 39 F4 CB on the wire after the payload.
// - Mid-frame reset (during DATA) -> next cycle tx_e=0, state IDLE; a new start_i produces a fresh preamble.

Source files
------------

// File: rtl/rmii_frame_tx_if.sv
// rmii_frame_tx_if: groups the MAC-side byte handshake (data, last_i,
// start_i, done_o), the clock enable and the RMII TX pins of rmii_frame_tx.
// The slave modport is the serializer's view; master is the driver's view.
interface rmii_frame_tx_if;
  logic [7:0] data;
  logic       en_i;
  logic       start_i;
  logic       last_i;
  logic [1:0] tx_d;
  logic       tx_e;
  logic       done_o;

  modport master (
    output data, en_i, start_i, last_i,
    input  tx_d, tx_e, done_o
  );

  modport slave (
    input  data, en_i, start_i, last_i,
    output tx_d, tx_e, done_o
  );
endinterface

// File: rtl/rmii_frame_tx.sv
// rmii_frame_tx: RMII (2-bit) Ethernet transmit serializer.
// Sends preamble + SFD, then payload bytes as dibits (LSB dibit first),
// optionally the FCS, and finishes with an inter-packet gap. Each payload
// byte load is acknowledged by a one-cycle done_o pulse so the source can
// present the next byte.
// Optional feature: define TX_FCS_EN to append CRC-32 (reflected 0xEDB88320)
// after the payload; without it the frame goes straight to the gap.
// rst_n is a synchronous, active-HIGH reset despite its name.
module rmii_frame_tx #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IPG_BYTES      = 12
) (
  input logic            ref_clk,
  input logic            rst_n,
  rmii_frame_tx_if.slave bus
);

  // Dibit counts for each frame section (4 dibits per byte).
  localparam int PRE_DIBITS = 4 * (PREAMBLE_BYTES + 1);
  localparam int IPG_DIBITS = 4 * IPG_BYTES;
  localparam int FCS_DIBITS = 16;
  localparam int CNT_MAX_A  = (PRE_DIBITS > IPG_DIBITS) ? PRE_DIBITS : IPG_DIBITS;
  localparam int CNT_MAX    = (CNT_MAX_A > FCS_DIBITS) ? CNT_MAX_A : FCS_DIBITS;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  // The section counter runs 1..LAST inside a state; the edge that enters
  // the state is dibit 0 of that section.
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_DIBITS - 1);
  localparam logic [CNT_W-1:0] IPG_LAST = CNT_W'(IPG_DIBITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef TX_FCS_EN
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(FCS_DIBITS);
  localparam logic [31:0]      CRC_POLY = 32'hEDB88320;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
`ifdef TX_FCS_EN
    ST_FCS,
`endif
    ST_IPG
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       rem_reg, rem_next;      // dibits of the current byte still to send
  logic [5:0]       shift_reg, shift_next;  // upper three dibits of the current byte
  logic             last_reg, last_next;    // current byte is the final payload byte
  logic [1:0]       tx_d_reg, tx_d_next;
  logic             tx_e_reg, tx_e_next;
  logic             done_reg, done_next;

`ifdef TX_FCS_EN
  // CRC runs over exactly the payload dibits that go on the wire. During
  // FCS the same register holds the inverted CRC and is shifted out.
  logic [31:0] crc_reg, crc_next;
  logic [1:0]  crc_din;
  logic [31:0] crc_stage [0:2];

  // Dibit entering the CRC: a shift edge sends shift_reg[1:0], a load edge sends data[1:0].
  assign crc_din      = (rem_reg != 2'd0) ? shift_reg[1:0] : bus.data[1:0];
  assign crc_stage[0] = crc_reg;

  // Two bit-serial reflected CRC steps, LSB of the dibit first.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_crc_bit
      assign crc_stage[gi+1] = (crc_stage[gi][0] ^ crc_din[gi])
                             ? ((crc_stage[gi] >> 1) ^ CRC_POLY)
                             : (crc_stage[gi] >> 1);
    end
  endgenerate
`endif

  assign bus.tx_d   = tx_d_reg;
  assign bus.tx_e   = tx_e_reg;
  assign bus.done_o = done_reg;

  // State and output registers; reset has priority and aborts any frame.
  always_ff @(posedge ref_clk) begin
    if (rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      rem_reg   <= 2'd0;
      shift_reg <= '0;
      last_reg  <= 1'b0;
      tx_d_reg  <= 2'b00;
      tx_e_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef TX_FCS_EN
      crc_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rem_reg   <= rem_next;
      shift_reg <= shift_next;
      last_reg  <= last_next;
      tx_d_reg  <= tx_d_next;
      tx_e_reg  <= tx_e_next;
      done_reg  <= done_next;
`ifdef TX_FCS_EN
      crc_reg   <= crc_next;
`endif
    end
  end

  // Next-state and next-output logic; nothing moves on edges with en_i=0,
  // except done_o which is only ever high for the cycle after a load edge.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rem_next   = rem_reg;
    shift_next = shift_reg;
    last_next  = last_reg;
    tx_d_next  = tx_d_reg;
    tx_e_next  = tx_e_reg;
    done_next  = 1'b0;
`ifdef TX_FCS_EN
    crc_next   = crc_reg;
`endif
    if (bus.en_i) begin
      case (state_reg)
        ST_IDLE: begin
          tx_e_next = 1'b0;
          tx_d_next = 2'b00;
          if (bus.start_i) begin
            // Start edge already drives preamble dibit 0.
            state_next = ST_PRE;
            cnt_next   = CNT_ONE;
            tx_e_next  = 1'b1;
            tx_d_next  = 2'b01;
`ifdef TX_FCS_EN
            crc_next   = '1;
`endif
          end
        end

        ST_PRE: begin
          tx_e_next = 1'b1;
          if (cnt_reg == PRE_LAST) begin
            // Final dibit of the SFD 0xD5; next edge is the first byte load.
            tx_d_next  = 2'b11;
            state_next = ST_DATA;
            rem_next   = 2'd0;
            last_next  = 1'b0;
          end else begin
            tx_d_next = 2'b01;
            cnt_next  = cnt_reg + CNT_ONE;
          end
        end

        ST_DATA: begin
          tx_e_next = 1'b1;
          if (rem_reg != 2'd0) begin
            // Shift out the remaining dibits of the current byte.
            tx_d_next  = shift_reg[1:0];
            shift_next = {2'b00, shift_reg[5:2]};
            rem_next   = rem_reg - 2'd1;
`ifdef TX_FCS_EN
            crc_next   = crc_stage[2];
`endif
          end else if (last_reg) begin
`ifdef TX_FCS_EN
            // Payload done: this edge sends FCS dibit 0, keep the rest inverted.
            state_next = ST_FCS;
            tx_d_next  = ~crc_reg[1:0];
            crc_next   = {2'b00, ~crc_reg[31:2]};
            cnt_next   = CNT_ONE;
`else
            // Payload done: this edge is the first gap dibit.
            state_next = ST_IPG;
            tx_e_next  = 1'b0;
            tx_d_next  = 2'b00;
            cnt_next   = CNT_ONE;
`endif
          end else begin
            // Byte boundary: load the next byte and acknowledge it.
            tx_d_next  = bus.data[1:0];
            shift_next = bus.data[7:2];
            rem_next   = 2'd3;
            last_next  = bus.last_i;
            done_next  = 1'b1;
`ifdef TX_FCS_EN
            crc_next   = crc_stage[2];
`endif
          end
        end

`ifdef TX_FCS_EN
        ST_FCS: begin
          if (cnt_reg == FCS_LAST) begin
            state_next = ST_IPG;
            tx_e_next  = 1'b0;
            tx_d_next  = 2'b00;
            cnt_next   = CNT_ONE;
          end else begin
            tx_e_next = 1'b1;
            tx_d_next = crc_reg[1:0];
            crc_next  = crc_reg >> 2;
            cnt_next  = cnt_reg + CNT_ONE;
          end
        end
`endif

        ST_IPG: begin
          tx_e_next = 1'b0;
          tx_d_next = 2'b00;
          if (cnt_reg == IPG_LAST) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end

        default: begin
          state_next = ST_IDLE;
          tx_e_next  = 1'b0;
          tx_d_next  = 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_frame_tx.sv
// tb_rmii_frame_tx: randomized self-checking bench for rmii_frame_tx.
// The reference model turns each frame into the list of dibits that must
// appear on the wire (preamble, payload, optional FCS, gap) and a checker
// pops one entry per enabled clock edge.
`timescale 1ns/1ps
module tb_rmii_frame_tx;

  localparam int PRE_DIBITS = 32;
  localparam int IPG_DIBITS = 48;
`ifdef TX_FCS_EN
  localparam int FCS_DIBITS = 16;
`else
  localparam int FCS_DIBITS = 0;
`endif
  localparam int BUSY_DIBITS_1B = PRE_DIBITS + 4 + FCS_DIBITS;

  typedef struct packed {
    logic       e;
    logic [1:0] d;
    logic       load;
    logic       first;
  } exp_t;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } src_t;

  logic ref_clk = 1'b0;
  logic rst_n   = 1'b1;
  always #10 ref_clk = ~ref_clk;

  rmii_frame_tx_if bus ();

  rmii_frame_tx dut (
    .ref_clk (ref_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  exp_t       exp_q [$];
  src_t       src_q [$];
  logic [7:0] fr_q  [$];

  int errors = 0;
  int checks = 0;
  int frames_started = 0;
  int en_mode = 0;
  int en_div = 0;
  int txe_cnt = 0;
  int done_cnt = 0;
  bit reset_seen = 0;
  bit present_req = 0;
  bit want_start = 0;

  logic chk_en, chk_rst, chk_start;
  logic hold_e, exp_done;
  logic [1:0] hold_d;
  exp_t ent;
  src_t src_ent;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Dibit j (0 = first on the wire) of a byte.
  function automatic logic [1:0] byte_dibit(input logic [7:0] b, input int j);
    return 2'((b >> (2 * j)) & 8'd3);
  endfunction

  // Byte-wise reflected CRC-32 over fr_q, returned already inverted (FCS value).
  function automatic logic [31:0] ref_fcs();
    logic [31:0] crc;
    crc = 32'hFFFFFFFF;
    foreach (fr_q[i]) begin
      crc = crc ^ {24'd0, fr_q[i]};
      for (int k = 0; k < 8; k++)
        crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    return ~crc;
  endfunction

  // Append the wire image of the frame held in fr_q to the expected stream.
  task automatic queue_frame();
    logic [31:0] fcs;
    for (int k = 0; k < PRE_DIBITS; k++)
      exp_q.push_back('{1'b1, (k == PRE_DIBITS - 1) ? 2'b11 : 2'b01, 1'b0, k == 0});
    foreach (fr_q[i]) begin
      for (int j = 0; j < 4; j++)
        exp_q.push_back('{1'b1, byte_dibit(fr_q[i], j), j == 0, 1'b0});
      src_q.push_back('{fr_q[i], i == fr_q.size() - 1});
    end
    fcs = ref_fcs();
    for (int j = 0; j < FCS_DIBITS; j++)
      exp_q.push_back('{1'b1, 2'((fcs >> (2 * j)) & 32'd3), 1'b0, 1'b0});
    for (int k = 0; k < IPG_DIBITS; k++)
      exp_q.push_back('{1'b0, 2'b00, 1'b0, 1'b0});
  endtask

  // Clock-enable pattern: always on, 1-in-10, or random.
  always @(negedge ref_clk) begin
    case (en_mode)
      0: bus.en_i = 1'b1;
      1: begin
        bus.en_i = (en_div == 0);
        en_div = (en_div == 9) ? 0 : en_div + 1;
      end
      default: bus.en_i = 1'($urandom_range(0, 1));
    endcase
  end

  // Byte source: presents the next byte on request or after each done_o.
  always @(negedge ref_clk) begin
    if (present_req || bus.done_o === 1'b1) begin
      if (src_q.size() > 0) begin
        src_ent = src_q.pop_front();
        bus.data   = src_ent.b;
        bus.last_i = src_ent.last;
      end
      present_req = 0;
    end
    bus.start_i = want_start;
    if (bus.done_o === 1'b1) done_cnt++;
    if (bus.tx_e === 1'b1) txe_cnt++;
  end

  // Checker: one model step per enabled edge, outputs compared every cycle.
  always @(posedge ref_clk) begin
    chk_en    = bus.en_i;
    chk_rst   = rst_n;
    chk_start = bus.start_i;
    #1;
    exp_done = 1'b0;
    if (chk_rst === 1'b1) begin
      exp_q.delete();
      hold_e = 1'b0;
      hold_d = 2'b00;
      reset_seen = 1;
    end else if (chk_en === 1'b1) begin
      if (exp_q.size() > 0 && (!exp_q[0].first || chk_start === 1'b1)) begin
        ent = exp_q.pop_front();
        hold_e   = ent.e;
        hold_d   = ent.d;
        exp_done = ent.load;
        if (ent.first) frames_started++;
      end else begin
        hold_e = 1'b0;
        hold_d = 2'b00;
      end
    end
    if (reset_seen) begin
      chk("tx_e", 32'(bus.tx_e), 32'(hold_e));
      chk("tx_d", 32'(bus.tx_d), 32'(hold_d));
      chk("done_o", 32'(bus.done_o), 32'(exp_done));
    end
  end

  task automatic begin_frames(input int n);
    int target;
    target = frames_started + n;
    @(negedge ref_clk);
    present_req = 1;
    want_start = 1;
    for (int c = 0; c < 8000; c++) begin
      @(negedge ref_clk);
      if (frames_started >= target) break;
    end
    chk("frames_started", 32'(frames_started), 32'(target));
    want_start = 0;
  endtask

  task automatic drain();
    for (int c = 0; c < 8000; c++) begin
      @(negedge ref_clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge ref_clk);
  endtask

  task automatic run_frames(input int n);
    begin_frames(n);
    drain();
  endtask

  initial begin
    int nfr, len, base;
    // Reset
    rst_n = 1'b1;
    repeat (2) @(posedge ref_clk);
    @(negedge ref_clk);
    chk("rst_tx_e", 32'(bus.tx_e), 32'd0);
    chk("rst_tx_d", 32'(bus.tx_d), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    rst_n = 1'b0;
    repeat (6) @(negedge ref_clk);
    chk("idle_tx_e", 32'(bus.tx_e), 32'd0);

    // Pin the model against hand-computed values
    chk("pin_c3_d0", 32'(byte_dibit(8'hC3, 0)), 32'd3);
    chk("pin_c3_d1", 32'(byte_dibit(8'hC3, 1)), 32'd0);
    chk("pin_c3_d2", 32'(byte_dibit(8'hC3, 2)), 32'd0);
    chk("pin_c3_d3", 32'(byte_dibit(8'hC3, 3)), 32'd3);
    chk("pin_91_d0", 32'(byte_dibit(8'h91, 0)), 32'd1);
    chk("pin_91_d1", 32'(byte_dibit(8'h91, 1)), 32'd0);
    chk("pin_91_d2", 32'(byte_dibit(8'h91, 2)), 32'd1);
    chk("pin_91_d3", 32'(byte_dibit(8'h91, 3)), 32'd2);
    fr_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("pin_fcs", ref_fcs(), 32'hCBF43926);

    // Single byte 0xC3 at full rate
    en_mode = 0;
    fr_q = '{8'hC3};
    queue_frame();
    txe_cnt = 0;
    done_cnt = 0;
    run_frames(1);
    chk("one_byte_txe_cycles", 32'(txe_cnt), 32'(BUSY_DIBITS_1B));
    chk("one_byte_done_pulses", 32'(done_cnt), 32'd1);

    // Two bytes 0xC3, 0x91
    fr_q = '{8'hC3, 8'h91};
    queue_frame();
    done_cnt = 0;
    run_frames(1);
    chk("two_byte_done_pulses", 32'(done_cnt), 32'd2);

    // 10M rate: enable pulsed 1 cycle in 10
    en_mode = 1;
    fr_q = '{8'hC3};
    queue_frame();
    txe_cnt = 0;
    done_cnt = 0;
    run_frames(1);
    chk("slow_txe_cycles", 32'(txe_cnt), 32'(10 * BUSY_DIBITS_1B));
    chk("slow_done_pulses", 32'(done_cnt), 32'd1);

    // "123456789" payload (FCS 26 39 F4 CB when compiled in)
    en_mode = 0;
    fr_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    queue_frame();
    run_frames(1);

    // Back-to-back frames with start_i held high
    fr_q = '{8'hC3};
    queue_frame();
    fr_q = '{8'h91};
    queue_frame();
    run_frames(2);

    // Randomized frames, enable patterns and back-to-back pairs
    for (int it = 0; it < 8; it++) begin
      en_mode = int'($urandom_range(0, 2));
      nfr = int'($urandom_range(1, 2));
      for (int f = 0; f < nfr; f++) begin
        len = int'($urandom_range(1, 6));
        fr_q.delete();
        for (int b = 0; b < len; b++) fr_q.push_back(8'($urandom_range(0, 255)));
        queue_frame();
      end
      run_frames(nfr);
      $display("frame set %0d: %0d frame(s), en_mode %0d, errors so far %0d", it, nfr, en_mode, errors);
    end

    // Mid-frame reset during DATA, then a fresh frame
    en_mode = 0;
    fr_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    queue_frame();
    base = done_cnt;
    begin_frames(1);
    for (int c = 0; c < 2000; c++) begin
      @(negedge ref_clk);
      if (done_cnt - base >= 2) break;
    end
    chk("mid_done_seen", 32'(done_cnt - base), 32'd2);
    rst_n = 1'b1;
    src_q.delete();
    @(posedge ref_clk);
    #2;
    chk("mid_rst_tx_e", 32'(bus.tx_e), 32'd0);
    chk("mid_rst_done", 32'(bus.done_o), 32'd0);
    @(negedge ref_clk);
    rst_n = 1'b0;
    repeat (3) @(negedge ref_clk);
    fr_q = '{8'hA5, 8'h5A};
    queue_frame();
    run_frames(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
